// File: rtl/adder_8bit.sv
// Registered WIDTH-bit adder with carry-out, signed overflow and zero flags.
// The sum comes from an explicit generate/propagate ripple chain and is registered one cycle after in_valid.
module adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] c,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // Per-bit generate, propagate and carry; kept as named nets so the chain can be probed.
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH:0]   carry_s;
  logic             ovf_s;
  logic             zero_s;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] c_d, c_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign g_s[i]       = a[i] & b[i];
    assign p_s[i]       = a[i] ^ b[i];
    assign sum_s[i]     = p_s[i] ^ carry_s[i];
    assign carry_s[i+1] = g_s[i] | (p_s[i] & carry_s[i]);
  end

  // Signed overflow: operands share a sign that the sum does not.
  assign ovf_s  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
  assign zero_s = (sum_s == {WIDTH{1'b0}});

  // Next-state: capture a new result on in_valid, otherwise hold result fields.
  always_comb begin
    valid_d = in_valid;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (in_valid) begin
      c_d    = sum_s;
      cout_d = carry_s[WIDTH];
      ovf_d  = ovf_s;
      zero_d = zero_s;
    end else begin
      c_d    = c_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      zero_d = zero_q;
    end
  end

  // Output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      c_q     <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q;
  assign c         = c_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_adder_8bit.sv
// Self-checking bench for adder_8bit: arithmetic reference model checked every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_adder_8bit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic [W-1:0] c;
  logic         cout, ovf, zero;

  int n_checks = 0;
  int n_errors = 0;

  adder_8bit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .c(c), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the sampled operands.
  logic [W:0]   m_full;
  logic         m_ovf_next;
  int           sa, sb, ssum;
  logic         m_valid;
  logic [W-1:0] m_c;
  logic         m_cout, m_ovf, m_zero;

  assign m_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

  always_comb begin
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    ssum = sa + sb + int'(cin);
    m_ovf_next = (ssum > (1 << (W-1)) - 1) || (ssum < -(1 << (W-1)));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_c     <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
      m_zero  <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        m_c    <= m_full[W-1:0];
        m_cout <= m_full[W];
        m_ovf  <= m_ovf_next;
        m_zero <= (m_full[W-1:0] == '0);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("model_c",     {56'd0, c},         {56'd0, m_c});
    chk("model_cout",  {63'd0, cout},      {63'd0, m_cout});
    chk("model_ovf",   {63'd0, ovf},       {63'd0, m_ovf});
    chk("model_zero",  {63'd0, zero},      {63'd0, m_zero});
  end

  task automatic chk_out(input string name, input logic v, input logic [W-1:0] ec,
                         input logic eco, input logic eov, input logic ez);
    chk({name, "_valid"}, {63'd0, out_valid}, {63'd0, v});
    chk({name, "_c"},     {56'd0, c},         {56'd0, ec});
    chk({name, "_cout"},  {63'd0, cout},      {63'd0, eco});
    chk({name, "_ovf"},   {63'd0, ovf},       {63'd0, eov});
    chk({name, "_zero"},  {63'd0, zero},      {63'd0, ez});
  endtask

  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
  endtask

  // Single operation issued at a negedge; result checked one cycle later.
  task automatic single_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tc, input logic [W-1:0] ec, input logic eco,
                           input logic eov, input logic ez);
    drive(ta, tb, tc);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out(name, 1'b1, ec, eco, eov, ez);
  endtask

  initial begin
    // Reset held with live inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(W'($urandom), W'($urandom), 1'($urandom));
      chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("post_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    single_op("no_carry", 8'd10, 8'd5, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("hold", 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

    single_op("uwrap", 8'd255, 8'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    single_op("neg_ovf", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    single_op("pos_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("idle_valid", {63'd0, out_valid}, 64'd0);

    // Back-to-back stream of three operations.
    drive(8'hFF, 8'h00, 1'b1);
    @(negedge clk);
    chk_out("stream0", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    drive(8'h12, 8'h34, 1'b1);
    @(negedge clk);
    chk_out("stream1", 1'b1, 8'h47, 1'b0, 1'b0, 1'b0);
    drive(8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk_out("stream2", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_end_valid", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset between edges while a result is valid.
    drive(8'h33, 8'h11, 1'b0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    chk_out("pre_async", 1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("async_clear", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("after_async_valid", {63'd0, out_valid}, 64'd0);
    end
    single_op("after_async_op", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

    // Randomized traffic; the per-cycle compare checks every result.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom);
      in_valid = ($urandom_range(3, 0) != 0);
      if ((i % 50) == 7) begin
        a = ~b;
      end else begin
        a = a;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
